controle_microondas: RTL and testbench
======================================

# controle_microondas

Sequencing controller for the `contador_nivel2` countdown timer (minutes / tens-of-seconds / unit-seconds, BCD).
- Collects an M:SS cook time from a digit keypad.
- Drives the counter's `load` and `enable` inputs.
- Watches its `zero` flag.
- Commands the magnetron and end-of-cook alarm.

It sits between the front-panel inputs (keypad, start/stop/clear, door switch) and the counter datapath in the top-level oven design.

## Interface
Parameters:
- `DONE_CYCLES`, default 10: number of clock cycles the alarm stays asserted in DONE (must be ≥1).

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `key_valid`  input  1  one-cycle strobe: `key_digit` is valid.
- `key_digit`  input  4  BCD digit 0–9; values 10–15 are ignored.
- `start`  input  1  level; sampled each cycle.
- `stop`  input  1  level; sampled each cycle.
- `clear`  input  1  level; sampled each cycle.
- `door_open`  input  1  1 = door open.
- `timer_zero`  input  1  `zero` output of the counter.
- `uni_sec`  output  4  entered unit seconds; drives the counter's load value.
- `dez_sec`  output  3  entered tens of seconds (0–5).
- `min`  output  4  entered minutes (0–9).
- `load`  output  1  counter load strobe.
- `enable`  output  1  counter count enable.
- `mag_on`  output  1  magnetron on.
- `alarm`  output  1  end-of-cook buzzer.
- `state`  output  3  current state encoding, for debug and display.

## Operation
States and encodings: IDLE=0, LOAD=1, COOK=2, PAUSED=3, DONE=4.

Digit entry (IDLE only, on `key_valid` with a digit ≤9):
- Shift `min`←`dez_sec`, `dez_sec`←`uni_sec[2:0]`, `uni_sec`←`key_digit`.
- If `uni_sec` >5, the shift is rejected and all three registers are unchanged.
- Keys in any other state are ignored.

Transitions, in priority order within each state:
- IDLE:
  - `clear` → zero all entry registers and stay in IDLE.
  - `start` with door closed and entry ≠0:00 → LOAD.
  - `start` with door open, or with entry all zero → ignored.
- LOAD:
  - `load`=1 and `enable`=0 for exactly one cycle, then → COOK unconditionally.
- COOK:
  - `enable`=1 and `mag_on`=1.
  - `timer_zero` → DONE. This has the highest priority; it wins over `door_open`, `stop` and `clear` in the same cycle.
  - Else `door_open` or `stop` → PAUSED.
  - Else `clear` → IDLE with entry registers zeroed.
- PAUSED:
  - `enable`=0 and `mag_on`=0; the counter holds its value.
  - `clear` → IDLE with entry zeroed.
  - `start` with door closed → COOK, with no reload.
  - `start` with door open → stay in PAUSED.
- DONE:
  - `alarm`=1 and a cycle counter runs.
  - After `DONE_CYCLES` cycles → IDLE.
  - `clear` ends DONE early → IDLE.
  - Entry registers are zeroed on DONE→IDLE.
  - `start` and keys are ignored.

Outputs:
- `load`, `enable`, `mag_on` and `alarm` are registered, decoded from the next state.
- The entry registers remain stable from LOAD until the next return to IDLE.

## Timing
- Reset:
  - `state`=IDLE.
  - `uni_sec`=`dez_sec`=`min`=0.
  - `load`=`enable`=`mag_on`=`alarm`=0.
  - DONE cycle counter = 0.
  - Reset mid-cook aborts immediately at the next edge; the counter is not reloaded.
- `start` sampled at edge N in IDLE:
  - `load`=1 during cycle N→N+1.
  - `enable`=`mag_on`=1 from edge N+1.
- Leaving COOK at edge K: `enable` and `mag_on` are 0 from edge K.
- `timer_zero` seen at edge K:
  - `alarm`=1 for exactly `DONE_CYCLES` cycles starting at edge K.
  - `state` returns to IDLE at edge K+`DONE_CYCLES`.
- `key_valid` to entry register update: 1 cycle.
- All inputs are treated as synchronous; `start`, `stop` and `clear` are level-sensitive, with no edge detection.

## Configuration
- `PAUSE_EN` defined:
  - `stop` or `door_open` in COOK → PAUSED, as described above.
- `PAUSE_EN` undefined:
  - PAUSED does not exist.
  - `stop` or `door_open` in COOK → IDLE with entry registers zeroed.
  - `start` requires a fresh entry, and cooking restarts through LOAD.
  - Encoding 3 is never produced.

## Test plan
- Reset, then keys 1, 2, 5 → `min`=1, `dez_sec`=2, `uni_sec`=5, `state`=0, all control outputs 0.
- Key 7 then key 3 → 7 is rejected as a tens digit; entry registers stay `uni_sec`=7, others 0.
- Entry 0:03, `start` at edge N:
  - `load` pulse in cycle N only.
  - `enable`=`mag_on`=1 from edge N+1.
  - `timer_zero` → `alarm` high for 10 cycles → IDLE with entry 0:00.
- `start` with entry 0:00, and `start` with `door_open`=1 → `state` stays 0 and `load` never asserts.
- `PAUSE_EN` set:
  - `door_open` during COOK → `state`=3, `enable`=0.
  - Door closed + `start` → `state`=2 with no `load` pulse.
- `PAUSE_EN` unset: the same door stimulus → `state`=0, entry zeroed.
- Simultaneous `timer_zero` and `door_open` in COOK → DONE (`state`=4, `alarm`=1). `clear` during DONE → IDLE next edge.

Source files
------------

// File: rtl/controle_microondas.sv
// ---------------------------------------------------------------------------
// controle_microondas
//
// Sequencing controller for the contador_nivel2 BCD countdown timer.
// It collects an M:SS cook time from a digit keypad, loads it into the
// counter, enables counting while the magnetron is on, and sounds the
// end-of-cook alarm for DONE_CYCLES clock cycles.
//
// Parameters:
//   DONE_CYCLES  cycles the alarm stays asserted in DONE (>= 1)
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   key_valid, key_digit  keypad strobe and BCD digit (10..15 ignored)
//   start, stop, clear    level-sensitive front-panel buttons
//   door_open             1 = door open
//   timer_zero            zero flag from the countdown counter
//   uni_sec/dez_sec/min   entered time, used as the counter load value
//   load, enable          counter load strobe and count enable
//   mag_on, alarm         magnetron and buzzer commands
//   state                 current state encoding (IDLE=0 .. DONE=4)
//
// Build option:
//   PAUSE_EN  when defined, stop/door_open during COOK goes to PAUSED and
//             start resumes without reloading; when undefined, they abort
//             to IDLE with the entry cleared and PAUSED is never entered.
// ---------------------------------------------------------------------------
module controle_microondas #(
  parameter int DONE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_open,
  input  logic       timer_zero,
  output logic [3:0] uni_sec,
  output logic [2:0] dez_sec,
  output logic [3:0] min,
  output logic       load,
  output logic       enable,
  output logic       mag_on,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COOK   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       uni_sec_q, uni_sec_d;
  logic [2:0]       dez_sec_q, dez_sec_d;
  logic [3:0]       min_q, min_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             enable_q, enable_d;
  logic             mag_on_q, mag_on_d;
  logic             alarm_q, alarm_d;

  logic digit_ok;
  logic entry_nz;
  logic zero_entry;

  assign digit_ok = key_valid && (key_digit <= 4'd9);
  assign entry_nz = (uni_sec_q != 4'd0) || (dez_sec_q != 3'd0) || (min_q != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      uni_sec_q <= 4'd0;
      dez_sec_q <= 3'd0;
      min_q     <= 4'd0;
      cnt_q     <= '0;
      load_q    <= 1'b0;
      enable_q  <= 1'b0;
      mag_on_q  <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      uni_sec_q <= uni_sec_d;
      dez_sec_q <= dez_sec_d;
      min_q     <= min_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      enable_q  <= enable_d;
      mag_on_q  <= mag_on_d;
      alarm_q   <= alarm_d;
    end
  end

  // Next-state logic. Digit entry only happens in IDLE when no start or
  // clear is being acted on, so the entry is frozen from LOAD onwards.
  always_comb begin
    state_d    = state_q;
    uni_sec_d  = uni_sec_q;
    dez_sec_d  = dez_sec_q;
    min_d      = min_q;
    cnt_d      = cnt_q;
    zero_entry = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          zero_entry = 1'b1;
        end else if (start && !door_open && entry_nz) begin
          state_d = ST_LOAD;
        end else if (digit_ok && (uni_sec_q <= 4'd5)) begin
          // The current unit digit becomes the tens digit, so it must be 0..5.
          min_d     = {1'b0, dez_sec_q};
          dez_sec_d = uni_sec_q[2:0];
          uni_sec_d = key_digit;
        end
      end

      ST_LOAD: begin
        state_d = ST_COOK;
      end

      ST_COOK: begin
        // The counter reaching zero outranks every panel input.
        if (timer_zero) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else if (door_open || stop) begin
`ifdef PAUSE_EN
          state_d = ST_PAUSED;
`else
          state_d    = ST_IDLE;
          zero_entry = 1'b1;
`endif
        end else if (clear) begin
          state_d    = ST_IDLE;
          zero_entry = 1'b1;
        end
      end

`ifdef PAUSE_EN
      ST_PAUSED: begin
        if (clear) begin
          state_d    = ST_IDLE;
          zero_entry = 1'b1;
        end else if (start && !door_open) begin
          state_d = ST_COOK;
        end
      end
`endif

      ST_DONE: begin
        if (clear || (cnt_q == CNT_LAST)) begin
          state_d    = ST_IDLE;
          zero_entry = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (zero_entry) begin
      uni_sec_d = 4'd0;
      dez_sec_d = 3'd0;
      min_d     = 4'd0;
    end
  end

  // Control outputs are registered from the next state so they change on
  // the same edge as the state itself.
  always_comb begin
    load_d   = (state_d == ST_LOAD);
    enable_d = (state_d == ST_COOK);
    mag_on_d = (state_d == ST_COOK);
    alarm_d  = (state_d == ST_DONE);
  end

  assign uni_sec = uni_sec_q;
  assign dez_sec = dez_sec_q;
  assign min     = min_q;
  assign load    = load_q;
  assign enable  = enable_q;
  assign mag_on  = mag_on_q;
  assign alarm   = alarm_q;
  assign state   = state_q;

endmodule

// File: tb/tb_controle_microondas.sv
// ---------------------------------------------------------------------------
// tb_controle_microondas
//
// Directed self-checking bench for controle_microondas with DONE_CYCLES=10.
// Each step drives one set of inputs, advances one clock and compares the
// outputs 1 time unit after the rising edge against hand-computed values.
// Control outputs are compared packed as {load, enable, mag_on, alarm}.
// ---------------------------------------------------------------------------
module tb_controle_microondas;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       clear;
  logic       door_open;
  logic       timer_zero;
  logic [3:0] uni_sec;
  logic [2:0] dez_sec;
  logic [3:0] min;
  logic       load;
  logic       enable;
  logic       mag_on;
  logic       alarm;
  logic [2:0] state;

  int tests_run;
  int tests_failed;
  int alarm_cycles;

  controle_microondas #(.DONE_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .door_open  (door_open),
    .timer_zero (timer_zero),
    .uni_sec    (uni_sec),
    .dez_sec    (dez_sec),
    .min        (min),
    .load       (load),
    .enable     (enable),
    .mag_on     (mag_on),
    .alarm      (alarm),
    .state      (state)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one input vector, then step past the next rising edge.
  task automatic applyStimulus(input logic kv, input logic [3:0] digit,
                               input logic st, input logic sp,
                               input logic cl, input logic door,
                               input logic tz);
    key_valid  = kv;
    key_digit  = digit;
    start      = st;
    stop       = sp;
    clear      = cl;
    door_open  = door;
    timer_zero = tz;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] entry();
    return {20'd0, min, 1'b0, dez_sec, uni_sec};
  endfunction

  function automatic logic [31:0] ctl();
    return {28'd0, load, enable, mag_on, alarm};
  endfunction

  // Expected entry packed the same way as entry()
  function automatic logic [31:0] ent(input int m, input int d, input int u);
    return {20'd0, 4'(m), 1'b0, 3'(d), 4'(u)};
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_entry", entry(), ent(0, 0, 0));
    checkOutput("reset_ctl", ctl(), 0);

    // Keys 1, 2, 5 give 1:25
    applyStimulus(1, 4'd1, 0, 0, 0, 0, 0);
    checkOutput("key1_entry", entry(), ent(0, 0, 1));
    applyStimulus(1, 4'd2, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("key125_entry", entry(), ent(1, 2, 5));
    checkOutput("key125_state", state, 0);
    checkOutput("key125_ctl", ctl(), 0);

    // Clear, then 7 followed by 3: 7 cannot become a tens digit
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("clear_entry", entry(), ent(0, 0, 0));
    applyStimulus(1, 4'd7, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'd3, 0, 0, 0, 0, 0);
    checkOutput("reject_tens", entry(), ent(0, 0, 7));
    applyStimulus(1, 4'd12, 0, 0, 0, 0, 0);
    checkOutput("ignore_digit12", entry(), ent(0, 0, 7));

    // Start with an all-zero entry is ignored
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("start_zero_state", state, 0);
    checkOutput("start_zero_load", load, 0);

    // Entry 0:03; start with door open is ignored
    applyStimulus(1, 4'd0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'd3, 0, 0, 0, 0, 0);
    checkOutput("entry_003", entry(), ent(0, 0, 3));
    applyStimulus(0, 0, 1, 0, 0, 1, 0);
    checkOutput("start_door_state", state, 0);
    checkOutput("start_door_load", load, 0);

    // Start at edge N: LOAD with load pulse, then COOK
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("load_state", state, 1);
    checkOutput("load_ctl", ctl(), 4'b1000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("cook_state", state, 2);
    checkOutput("cook_ctl", ctl(), 4'b0110);
    applyStimulus(1, 4'd9, 0, 0, 0, 0, 0);
    checkOutput("cook_key_ignored", entry(), ent(0, 0, 3));

    // timer_zero: alarm for exactly 10 cycles, then IDLE with entry cleared
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("done_state", state, 4);
    checkOutput("done_ctl", ctl(), 4'b0001);
    alarm_cycles = 1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      if (alarm && state == 3'd4) alarm_cycles++;
    end
    checkOutput("alarm_cycles", alarm_cycles, 10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("done_exit_state", state, 0);
    checkOutput("done_exit_ctl", ctl(), 0);
    checkOutput("done_exit_entry", entry(), ent(0, 0, 0));

    // Door opened during COOK
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("cook2_state", state, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
`ifdef PAUSE_EN
    checkOutput("pause_state", state, 3);
    checkOutput("pause_ctl", ctl(), 0);
    checkOutput("pause_entry", entry(), ent(0, 0, 5));
    applyStimulus(0, 0, 1, 0, 0, 1, 0);
    checkOutput("pause_door_start", state, 3);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("resume_state", state, 2);
    checkOutput("resume_ctl", ctl(), 4'b0110);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("stop_state", state, 3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("pause_clear_state", state, 0);
    checkOutput("pause_clear_entry", entry(), ent(0, 0, 0));
`else
    checkOutput("abort_state", state, 0);
    checkOutput("abort_ctl", ctl(), 0);
    checkOutput("abort_entry", entry(), ent(0, 0, 0));
`endif

    // timer_zero wins over door_open and stop in the same cycle
    applyStimulus(1, 4'd6, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 1);
    checkOutput("tz_prio_state", state, 4);
    checkOutput("tz_prio_alarm", alarm, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("done_hold_state", state, 4);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("done_clear_state", state, 0);
    checkOutput("done_clear_ctl", ctl(), 0);
    checkOutput("done_clear_entry", entry(), ent(0, 0, 0));

    // Reset in the middle of cooking
    applyStimulus(1, 4'd4, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("cook3_state", state, 2);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    checkOutput("midreset_state", state, 0);
    checkOutput("midreset_ctl", ctl(), 0);
    checkOutput("midreset_entry", entry(), ent(0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
